// File: rtl/panda_pkg.sv
// Shared types and constants for the panda core pipeline control logic.
package panda_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StMemErr  = 2'd2
  } hazard_state_e;

  // Forward-select value meaning "take the operand from the register file".
  localparam int unsigned FWD_RF = 0;

endpackage

// File: rtl/panda_fwd_sel.sv
// Single-operand forwarding priority selector: picks the youngest in-flight writer of the
// operand register, or the register file when none matches (x0 is never forwarded).
module panda_fwd_sel
  import panda_pkg::*;
#(
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [REG_AW-1:0]         op_addr_i,
  input  logic [NUM_FWD*REG_AW-1:0] rd_addr_fwd_i,
  input  logic [NUM_FWD-1:0]        rd_we_fwd_i,
  output logic [SEL_W-1:0]          sel_o
);

  always_comb begin
    sel_o = SEL_W'(FWD_RF);
    // Walk oldest to youngest so the lowest matching index overwrites the rest.
    for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
      if (rd_we_fwd_i[k] && (op_addr_i != '0) &&
          (rd_addr_fwd_i[k*REG_AW +: REG_AW] == op_addr_i)) begin
        sel_o = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/panda_hazard_ctrl.sv
// Pipeline hazard control: N-source forwarding, load-use interlock, redirect flush and
// data-memory wait/timeout stalls. Optional PANDA_PERF_CNT_EN adds stall/flush counters.
module panda_hazard_ctrl
  import panda_pkg::*;
#(
  parameter int unsigned NUM_FWD     = 2,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [REG_AW-1:0]              rs1_addr_id_i,
  input  logic [REG_AW-1:0]              rs2_addr_id_i,
  input  logic                           rs1_used_id_i,
  input  logic                           rs2_used_id_i,
  input  logic [REG_AW-1:0]              rs1_addr_ex_i,
  input  logic [REG_AW-1:0]              rs2_addr_ex_i,
  input  logic [REG_AW-1:0]              rd_addr_ex_i,
  input  logic                           rd_we_ex_i,
  input  logic                           load_ex_i,
  input  logic [NUM_FWD*REG_AW-1:0]      rd_addr_fwd_i,
  input  logic [NUM_FWD-1:0]             rd_we_fwd_i,
  input  logic                           redirect_i,
  input  logic                           data_req_i,
  input  logic                           data_rvalid_i,
  output logic                           stall_if_o,
  output logic                           stall_id_o,
  output logic                           stall_ex_o,
  output logic                           stall_mem_o,
  output logic                           flush_id_o,
  output logic                           flush_ex_o,
  output logic [$clog2(NUM_FWD+1)-1:0]   forward_rs1_o,
  output logic [$clog2(NUM_FWD+1)-1:0]   forward_rs2_o,
  output logic                           mem_err_o,
  output logic [CNT_W-1:0]               stall_cycles_o,
  output logic [CNT_W-1:0]               flush_count_o
);

  localparam int unsigned SEL_W  = $clog2(NUM_FWD + 1);
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  hazard_state_e     state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_stall;
  logic              load_use;

  panda_fwd_sel #(
    .NUM_FWD (NUM_FWD),
    .REG_AW  (REG_AW),
    .SEL_W   (SEL_W)
  ) u_fwd_rs1 (
    .op_addr_i     (rs1_addr_ex_i),
    .rd_addr_fwd_i (rd_addr_fwd_i),
    .rd_we_fwd_i   (rd_we_fwd_i),
    .sel_o         (forward_rs1_o)
  );

  panda_fwd_sel #(
    .NUM_FWD (NUM_FWD),
    .REG_AW  (REG_AW),
    .SEL_W   (SEL_W)
  ) u_fwd_rs2 (
    .op_addr_i     (rs2_addr_ex_i),
    .rd_addr_fwd_i (rd_addr_fwd_i),
    .rd_we_fwd_i   (rd_we_fwd_i),
    .sel_o         (forward_rs2_o)
  );

  // The error cycle abandons the access, so an unanswered request must not stall there.
  assign mem_stall = data_req_i & ~data_rvalid_i & (state_q != StMemErr);

  assign load_use = load_ex_i & rd_we_ex_i & (rd_addr_ex_i != '0) &
                    ((rs1_used_id_i & (rs1_addr_id_i == rd_addr_ex_i)) |
                     (rs2_used_id_i & (rs2_addr_id_i == rd_addr_ex_i)));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    mem_err_o   = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          wait_cnt_d = WAIT_W'(1);
          state_d    = (MEM_TIMEOUT == 1) ? StMemErr : StMemWait;
        end
      end
      StMemWait: begin
        if (!mem_stall) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if ((MEM_TIMEOUT != 0) && (wait_cnt_d == WAIT_W'(MEM_TIMEOUT))) begin
            state_d = StMemErr;
          end
        end
      end
      StMemErr: begin
        mem_err_o  = 1'b1;
        state_d    = StRun;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase

    if (mem_stall) begin
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
    end else if (redirect_i) begin
      // The ID instruction is squashed, so any load-use match is irrelevant.
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end else if (load_use) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end

    if (rst_i) begin
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      stall_ex_o  = 1'b0;
      stall_mem_o = 1'b0;
      flush_id_o  = 1'b0;
      flush_ex_o  = 1'b0;
      mem_err_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PANDA_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q +
                     CNT_W'(stall_if_o | stall_id_o | stall_ex_o | stall_mem_o);
    flush_count_d  = flush_count_q + CNT_W'(flush_id_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_panda_hazard_ctrl.sv
// Scoreboard bench for panda_hazard_ctrl (NUM_FWD=3, MEM_TIMEOUT=4).
module tb_panda_hazard_ctrl;

  localparam int NUM_FWD     = 3;
  localparam int REG_AW      = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;
  localparam int SEL_W       = 2;
`ifdef PANDA_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [10:0] val;
  } exp_t;

  typedef struct {
    string            tag;
    logic [CNT_W-1:0] stalls;
    logic [CNT_W-1:0] flushes;
  } cnt_exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [REG_AW-1:0]         rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex;
  logic                      rs1_used, rs2_used, rd_we_ex, load_ex;
  logic [NUM_FWD*REG_AW-1:0] fwd_addr;
  logic [NUM_FWD-1:0]        fwd_we;
  logic                      redirect, data_req, data_rvalid;
  logic                      stall_if, stall_id, stall_ex, stall_mem;
  logic                      flush_id, flush_ex, mem_err;
  logic [SEL_W-1:0]          fwd1, fwd2;
  logic [CNT_W-1:0]          stall_cycles, flush_count;

  int       n_pass = 0;
  int       n_total = 0;
  exp_t     sb_q[$];
  cnt_exp_t cnt_q[$];

  always #5 clk = ~clk;

  panda_hazard_ctrl #(
    .NUM_FWD     (NUM_FWD),
    .REG_AW      (REG_AW),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rs1_addr_id_i  (rs1_id),
    .rs2_addr_id_i  (rs2_id),
    .rs1_used_id_i  (rs1_used),
    .rs2_used_id_i  (rs2_used),
    .rs1_addr_ex_i  (rs1_ex),
    .rs2_addr_ex_i  (rs2_ex),
    .rd_addr_ex_i   (rd_ex),
    .rd_we_ex_i     (rd_we_ex),
    .load_ex_i      (load_ex),
    .rd_addr_fwd_i  (fwd_addr),
    .rd_we_fwd_i    (fwd_we),
    .redirect_i     (redirect),
    .data_req_i     (data_req),
    .data_rvalid_i  (data_rvalid),
    .stall_if_o     (stall_if),
    .stall_id_o     (stall_id),
    .stall_ex_o     (stall_ex),
    .stall_mem_o    (stall_mem),
    .flush_id_o     (flush_id),
    .flush_ex_o     (flush_ex),
    .forward_rs1_o  (fwd1),
    .forward_rs2_o  (fwd2),
    .mem_err_o      (mem_err),
    .stall_cycles_o (stall_cycles),
    .flush_count_o  (flush_count)
  );

  // Packed layout: {stall if,id,ex,mem | flush id,ex | mem_err | fwd_rs1 | fwd_rs2}
  function automatic logic [10:0] mk(logic [3:0] st, logic [1:0] fl, logic er,
                                     logic [1:0] f1, logic [1:0] f2);
    return {st, fl, er, f1, f2};
  endfunction

  function automatic logic [10:0] obs();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_err, fwd1, fwd2};
  endfunction

  function automatic logic [SEL_W-1:0] ref_sel(logic [REG_AW-1:0] a);
    logic [SEL_W-1:0] s = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (s == '0 && a != '0 && fwd_we[k] && fwd_addr[k*REG_AW +: REG_AW] == a)
        s = SEL_W'(k + 1);
    end
    return s;
  endfunction

  task automatic idle_inputs();
    rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0; rd_ex = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; rd_we_ex = 1'b0; load_ex = 1'b0;
    fwd_addr = '0; fwd_we = '0;
    redirect = 1'b0; data_req = 1'b0; data_rvalid = 1'b0;
  endtask

  task automatic push_exp(string tag, logic [10:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic push_cnt(string tag, logic [CNT_W-1:0] s, logic [CNT_W-1:0] f);
    cnt_exp_t c;
    c.tag = tag;
    c.stalls = s;
    c.flushes = f;
    cnt_q.push_back(c);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    cnt_exp_t c;
    // Inputs that would otherwise stall and flush are held while in reset.
    idle_inputs();
    rst = 1'b1; data_req = 1'b1; redirect = 1'b1;
    next_cycle();
    push_exp("reset_outputs", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
    push_cnt("reset_counters", '0, '0);
    @(negedge clk);
    e = sb_q.pop_front();
    n_total++;
    if (obs() !== e.val) $display("FAIL %s: got %b want %b", e.tag, obs(), e.val);
    else n_pass++;
    c = cnt_q.pop_front();
    n_total++;
    if (stall_cycles !== c.stalls || flush_count !== c.flushes)
      $display("FAIL %s: got %0d/%0d want %0d/%0d", c.tag, stall_cycles, flush_count,
               c.stalls, c.flushes);
    else n_pass++;
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    push_exp("post_reset_idle", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
    @(negedge clk);
    e = sb_q.pop_front();
    n_total++;
    if (obs() !== e.val) $display("FAIL %s: got %b want %b", e.tag, obs(), e.val);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_forwarding();
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      if (i == 0) begin
        rs1_ex = 5'd5; rs2_ex = 5'd3;
        fwd_addr = {5'd5, 5'd3, 5'd5}; fwd_we = 3'b111;
        push_exp("fwd_youngest_wins", mk(4'b0, 2'b0, 1'b0, 2'd1, 2'd2));
      end else if (i == 1) begin
        rs1_ex = 5'd5; rs2_ex = 5'd3;
        fwd_addr = {5'd5, 5'd3, 5'd5}; fwd_we = 3'b100;
        push_exp("fwd_oldest_only", mk(4'b0, 2'b0, 1'b0, 2'd3, 2'd0));
      end else if (i == 2) begin
        fwd_we = 3'b111;
        push_exp("fwd_x0_never", mk(4'b0, 2'b0, 1'b0, 2'd0, 2'd0));
      end else begin
        rs1_ex = REG_AW'($urandom_range(0, 3));
        rs2_ex = REG_AW'($urandom_range(0, 3));
        for (int k = 0; k < NUM_FWD; k++)
          fwd_addr[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
        fwd_we = NUM_FWD'($urandom_range(0, 7));
        push_exp("fwd_random", mk(4'b0, 2'b0, 1'b0, ref_sel(rs1_ex), ref_sel(rs2_ex)));
      end
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if (obs() !== e.val) $display("FAIL %s[%0d]: got %b want %b", e.tag, i, obs(), e.val);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      rd_we_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd3; rs1_used = 1'b1;
      unique case (i)
        0: begin
          load_ex = 1'b1; rs2_id = 5'd7; rs2_used = 1'b1;
          push_exp("load_use_rs2", mk(4'b1100, 2'b01, 1'b0, 2'd0, 2'd0));
        end
        1: begin
          rs2_id = 5'd7; rs2_used = 1'b1;
          push_exp("load_use_released", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
        end
        2: begin
          load_ex = 1'b1; rs2_id = 5'd7; rs2_used = 1'b0;
          push_exp("load_use_unused_src", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
        end
        3: begin
          load_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
          push_exp("load_use_x0", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
        end
        default: begin
          load_ex = 1'b1; rd_we_ex = 1'b0; rs1_id = 5'd7;
          push_exp("load_use_no_we", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
        end
      endcase
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if (obs() !== e.val) $display("FAIL %s: got %b want %b", e.tag, obs(), e.val);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      data_req = (i < 4);
      data_rvalid = (i == 3);
      if (i < 3) push_exp("mem_wait_stall", mk(4'b1111, 2'b00, 1'b0, 2'd0, 2'd0));
      else push_exp("mem_wait_release", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if (obs() !== e.val) $display("FAIL %s[%0d]: got %b want %b", e.tag, i, obs(), e.val);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      data_req = (i < 7);
      data_rvalid = (i == 6);
      if (i < 4) push_exp("timeout_stall", mk(4'b1111, 2'b00, 1'b0, 2'd0, 2'd0));
      else if (i == 4) push_exp("timeout_err", mk(4'b0000, 2'b00, 1'b1, 2'd0, 2'd0));
      else if (i == 5) push_exp("timeout_rerun", mk(4'b1111, 2'b00, 1'b0, 2'd0, 2'd0));
      else push_exp("timeout_after", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if (obs() !== e.val) $display("FAIL %s[%0d]: got %b want %b", e.tag, i, obs(), e.val);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      rst = (i == 2);
      data_req = (i < 7);
      if (i == 2) push_exp("midrst_quiet", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
      else if (i < 7) push_exp("midrst_stall", mk(4'b1111, 2'b00, 1'b0, 2'd0, 2'd0));
      else if (i == 7) push_exp("midrst_full_timeout", mk(4'b0000, 2'b00, 1'b1, 2'd0, 2'd0));
      else push_exp("midrst_idle", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if (obs() !== e.val) $display("FAIL %s[%0d]: got %b want %b", e.tag, i, obs(), e.val);
      else n_pass++;
      next_cycle();
    end
    rst = 1'b0;
  endtask

  task automatic test_redirect();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      redirect = (i < 4);
      data_req = (i < 3);
      data_rvalid = (i == 2);
      if (i == 3) begin
        load_ex = 1'b1; rd_we_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; rs1_used = 1'b1;
      end
      if (i < 2) push_exp("redir_held_in_wait", mk(4'b1111, 2'b00, 1'b0, 2'd0, 2'd0));
      else if (i == 2) push_exp("redir_on_release", mk(4'b0000, 2'b11, 1'b0, 2'd0, 2'd0));
      else if (i == 3) push_exp("redir_over_load_use", mk(4'b0000, 2'b11, 1'b0, 2'd0, 2'd0));
      else push_exp("redir_idle", mk(4'b0000, 2'b00, 1'b0, 2'd0, 2'd0));
      @(negedge clk);
      e = sb_q.pop_front();
      n_total++;
      if (obs() !== e.val) $display("FAIL %s[%0d]: got %b want %b", e.tag, i, obs(), e.val);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_perf_counters();
    cnt_exp_t c;
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    // 3 mem-wait stalls, release, 1 load-use, 2 redirects.
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      data_req = (i < 4);
      data_rvalid = (i == 3);
      if (i == 4) begin
        load_ex = 1'b1; rd_we_ex = 1'b1; rd_ex = 5'd9; rs2_id = 5'd9; rs2_used = 1'b1;
      end
      redirect = (i == 5 || i == 6);
      next_cycle();
    end
    idle_inputs();
    push_cnt("perf_counts", PERF_ON ? CNT_W'(4) : '0, PERF_ON ? CNT_W'(2) : '0);
    @(negedge clk);
    c = cnt_q.pop_front();
    n_total++;
    if (stall_cycles !== c.stalls || flush_count !== c.flushes)
      $display("FAIL %s: got %0d/%0d want %0d/%0d", c.tag, stall_cycles, flush_count,
               c.stalls, c.flushes);
    else n_pass++;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      data_req = 1'b1;
      rst = (i == 2);
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    push_cnt("perf_cleared_mid_wait", '0, '0);
    @(negedge clk);
    c = cnt_q.pop_front();
    n_total++;
    if (stall_cycles !== c.stalls || flush_count !== c.flushes)
      $display("FAIL %s: got %0d/%0d want %0d/%0d", c.tag, stall_cycles, flush_count,
               c.stalls, c.flushes);
    else n_pass++;
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_redirect();
    test_perf_counters();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
